instr_decode_queue: RTL and testbench
=====================================

Name: instr_decode_queue

Overview:
- Parametrised successor to the combinational opcode decoder, positioned between fetch and the controller/datapath.
- Buffers fetched 16-bit instructions in a FIFO with a valid/ready handshake on both sides.
- Decodes each instruction into a registered op, format, register, and extended-immediate bundle.
- Immediate-format selection and zero/sign extension are set by mask parameters instead of hard-wired logic. Adds flush, occupancy and a retired-instruction counter.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- DATA_W, 16, width of the extended immediate; >=8.
- IMM_MAJOR_MASK, 16'hFEEE, bit i set: major opcode i uses immediate/branch format. Default covers majors 1-3, 5-7 and 9-15.
- BRANCH_MAJOR, 4'hC, major opcode reported as branch format.
- ZEXT_MASK, 16'h0000, bit i set: major i zero-extends its immediate; otherwise the immediate is sign-extended.
- CNT_W, 16, width of the retired counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all buffered and presented instructions
- in_valid  in  1  fetch offers in_instr
- in_ready  out  1  queue can accept
- in_instr  in  16  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- out_op  out  8  decoded instruction op
- out_fmt  out  2  0 = reg-reg, 1 = immediate, 2 = branch
- out_rdest  out  4  instr[11:8]
- out_rsrc  out  4  instr[3:0]
- out_imm  out  DATA_W  extended instr[7:0]; 0 for reg-reg
- out_instr  out  16  raw instruction, passed through
- occupancy  out  $clog2(DEPTH+1)  FIFO entries currently held (output register excluded)
- retired_count  out  CNT_W  count of bundles handed off

Behaviour:
- Reset (asynchronous, active-low): FIFO empty, read and write pointers 0, out_valid=0, all out_* data=0, occupancy=0, retired_count=0, in_ready=1 once reset deasserts.
- Decode, with major=instr[15:12] and ext=instr[7:4]:
  - If IMM_MAJOR_MASK[major]: out_op={major,4'h0}; out_fmt=2 when major==BRANCH_MAJOR, else 1.
  - Otherwise: out_op={major,ext}, out_fmt=0, out_imm=0.
  - Immediate extension: zero-extend when ZEXT_MASK[major], else sign-extend from bit 7.
- Decode is evaluated when the output register loads; all out_* are registered and held stable while out_valid && !out_ready.
- in_ready = (occupancy < DEPTH). It is registered-path only, with no combinational dependence on out_ready. Input is accepted when in_valid && in_ready && !flush.
- Output register load condition ("slot free"): !out_valid || out_ready.
- Load priority per cycle:
  - FIFO non-empty and slot free: load FIFO head and pop. An accepted input in the same cycle is pushed (simultaneous push/pop; occupancy unchanged).
  - FIFO empty, slot free, input accepted: bypass into the output register. Latency 1 cycle (accept at edge N, out_valid visible after edge N).
  - Slot not free and input accepted: push to FIFO.
  - Slot free and nothing to load: out_valid falls to 0.
- Order is strictly preserved; bypass happens only when the FIFO is empty.
- Full: occupancy==DEPTH means in_ready=0. A pop that cycle frees one entry, and in_ready rises the next cycle.
- Pointers wrap modulo DEPTH.
- retired_count increments on out_valid && out_ready and wraps at 2^CNT_W. It is not cleared by flush.
- flush takes priority over everything in its cycle:
  - Next cycle: FIFO empty, out_valid=0.
  - An input offered in the flush cycle is dropped.
  - A handoff (out_valid && out_ready) in the flush cycle still counts as retired.
- reset_n asserted mid-operation returns everything to reset values immediately, independent of clk.

Test Plan:
- Bypass, reg-reg: after reset, in_instr=16'h0295 with out_ready=1 -> next cycle out_valid=1, out_op=8'h09, out_fmt=0, out_rdest=2, out_rsrc=5, out_imm=0, occupancy=0.
- Immediate sign-extension (DATA_W=16): 16'h53F0 -> out_op=8'h50, out_fmt=1, out_imm=16'hFFF0. Rerun with ZEXT_MASK=16'h0020 -> out_imm=16'h00F0.
- Branch and reg-reg op: 16'hC410 -> out_op=8'hC0, out_fmt=2, out_imm=16'h0010. 16'h8142 -> out_op=8'h84, out_fmt=0.
- Backpressure/full (DEPTH=4): out_ready=0, stream 6 instructions -> 1 held in the output register, occupancy=4, in_ready=0. Release out_ready -> all 5 delivered in order, retired_count=5.
- Simultaneous push/pop: FIFO holding 2, in_valid=1 and out_ready=1 each cycle -> occupancy stays 2 and order is preserved.
- Flush: occupancy=3, out_valid=1, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, input dropped. Assert reset_n low asynchronously mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - buffered instruction decoder between fetch and controller
//
// Accepts raw 16-bit instructions from fetch, queues them in a DEPTH-entry FIFO and
// presents one decoded bundle at a time from a registered output stage.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   flush                discard everything buffered and presented this cycle
//   in_valid/in_ready    fetch handshake, in_instr carries the raw instruction
//   out_valid/out_ready  consumer handshake for the decoded bundle
//   out_op/out_fmt       decoded op and format (0 reg-reg, 1 immediate, 2 branch)
//   out_rdest/out_rsrc   register fields instr[11:8] / instr[3:0]
//   out_imm              extended instr[7:0], 0 for reg-reg
//   out_instr            raw instruction of the presented bundle
//   occupancy            FIFO entries held, output register excluded
//   retired_count        bundles handed off, wrapping
module instr_decode_queue #(
  parameter int          DEPTH          = 4,
  parameter int          DATA_W         = 16,
  parameter logic [15:0] IMM_MAJOR_MASK = 16'hFEEE,
  parameter logic [3:0]  BRANCH_MAJOR   = 4'hC,
  parameter logic [15:0] ZEXT_MASK      = 16'h0000,
  parameter int          CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_op,
  output logic [1:0]                   out_fmt,
  output logic [3:0]                   out_rdest,
  output logic [3:0]                   out_rsrc,
  output logic [DATA_W-1:0]            out_imm,
  output logic [15:0]                  out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             retired_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [15:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_count;
  logic               r_out_valid;
  logic [7:0]         r_out_op;
  logic [1:0]         r_out_fmt;
  logic [3:0]         r_out_rdest;
  logic [3:0]         r_out_rsrc;
  logic [DATA_W-1:0]  r_out_imm;
  logic [15:0]        r_out_instr;
  logic [CNT_W-1:0]   r_retired;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_slot_free;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic               w_load;
  logic [15:0]        w_load_instr;
  logic [3:0]         w_major;
  logic [7:0]         w_imm8;
  logic [DATA_W-1:0]  w_sext;
  logic [DATA_W-1:0]  w_zext;
  logic [7:0]         w_dec_op;
  logic [1:0]         w_dec_fmt;
  logic [DATA_W-1:0]  w_dec_imm;
  logic [OCC_W-1:0]   w_count_nxt;

  // in_ready depends only on the stored count, never on out_ready.
  assign w_in_ready   = (r_count < OCC_W'(DEPTH));
  assign w_accept     = in_valid && w_in_ready && !flush;
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_fifo_empty = (r_count == '0);

  // The FIFO head always wins the output slot; bypass only when the FIFO is
  // empty keeps delivery order strict.
  assign w_pop        = !flush && w_slot_free && !w_fifo_empty;
  assign w_bypass     = !flush && w_slot_free && w_fifo_empty && w_accept;
  assign w_push       = w_accept && !w_bypass;
  assign w_load       = w_pop || w_bypass;
  assign w_load_instr = w_pop ? r_mem[r_rd_ptr] : in_instr;

  assign w_major = w_load_instr[15:12];
  assign w_imm8  = w_load_instr[7:0];

  generate
    if (DATA_W > 8) begin : g_wide_imm
      assign w_sext = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
      assign w_zext = {{(DATA_W-8){1'b0}}, w_imm8};
    end else begin : g_narrow_imm
      assign w_sext = w_imm8;
      assign w_zext = w_imm8;
    end
  endgenerate

  always_comb begin
    w_dec_op  = {w_major, w_load_instr[7:4]};
    w_dec_fmt = 2'd0;
    w_dec_imm = '0;
    if (IMM_MAJOR_MASK[w_major]) begin
      w_dec_op  = {w_major, 4'h0};
      w_dec_fmt = (w_major == BRANCH_MAJOR) ? 2'd2 : 2'd1;
      w_dec_imm = ZEXT_MASK[w_major] ? w_zext : w_sext;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + OCC_W'(1);
      2'b01:   w_count_nxt = r_count - OCC_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_fmt   <= '0;
      r_out_rdest <= '0;
      r_out_rsrc  <= '0;
      r_out_imm   <= '0;
      r_out_instr <= '0;
      r_retired   <= '0;
    end else begin
      // A handoff in a flush cycle still retires.
      if (r_out_valid && out_ready) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= w_count_nxt;
        if (w_slot_free) begin
          r_out_valid <= w_load;
        end
        if (w_load) begin
          r_out_op    <= w_dec_op;
          r_out_fmt   <= w_dec_fmt;
          r_out_rdest <= w_load_instr[11:8];
          r_out_rsrc  <= w_load_instr[3:0];
          r_out_imm   <= w_dec_imm;
          r_out_instr <= w_load_instr;
        end
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_op        = r_out_op;
  assign out_fmt       = r_out_fmt;
  assign out_rdest     = r_out_rdest;
  assign out_rsrc      = r_out_rsrc;
  assign out_imm       = r_out_imm;
  assign out_instr     = r_out_instr;
  assign occupancy     = r_count;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - self-checking bench for instr_decode_queue
module tb_instr_decode_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam int OCC_W  = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_op;
  logic [1:0]        out_fmt;
  logic [3:0]        out_rdest;
  logic [3:0]        out_rsrc;
  logic [DATA_W-1:0] out_imm;
  logic [15:0]       out_instr;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  retired_count;

  logic              z_in_ready;
  logic              z_out_valid;
  logic [7:0]        z_out_op;
  logic [1:0]        z_out_fmt;
  logic [3:0]        z_out_rdest;
  logic [3:0]        z_out_rsrc;
  logic [DATA_W-1:0] z_out_imm;
  logic [15:0]       z_out_instr;
  logic [OCC_W-1:0]  z_occupancy;
  logic [CNT_W-1:0]  z_retired_count;

  instr_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ZEXT_MASK(16'h0000), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_fmt(out_fmt), .out_rdest(out_rdest), .out_rsrc(out_rsrc),
    .out_imm(out_imm), .out_instr(out_instr),
    .occupancy(occupancy), .retired_count(retired_count)
  );

  // Second instance with major 5 zero-extending, driven identically.
  instr_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ZEXT_MASK(16'h0020), .CNT_W(CNT_W)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_instr(in_instr),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .out_op(z_out_op), .out_fmt(z_out_fmt), .out_rdest(z_out_rdest), .out_rsrc(z_out_rsrc),
    .out_imm(z_out_imm), .out_instr(z_out_instr),
    .occupancy(z_occupancy), .retired_count(z_retired_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] imm_mask  = 16'hFEEE;
  logic [15:0] zmask_dflt = 16'h0000;
  logic [15:0] zmask_z    = 16'h0020;

  // Reference: a list of held instructions plus one presented slot.
  logic [15:0]      m_q[$];
  bit               m_valid;
  logic [15:0]      m_instr;
  logic [CNT_W-1:0] m_ret;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_valid = 1'b0;
      m_instr = '0;
      m_ret   = '0;
    end else begin
      bit acc;
      bit slot;
      if (m_valid && out_ready) m_ret = m_ret + 1'b1;
      acc  = in_valid && (m_q.size() < DEPTH) && !flush;
      slot = !m_valid || out_ready;
      if (flush) begin
        m_q.delete();
        m_valid = 1'b0;
      end else begin
        if (acc) m_q.push_back(in_instr);
        if (slot) begin
          if (m_q.size() > 0) begin
            m_instr = m_q.pop_front();
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
      end
    end
  end

  function automatic void exp_decode(input logic [15:0] ins, input logic [15:0] zmask,
                                     output logic [7:0] op, output logic [1:0] fmt,
                                     output logic [15:0] imm);
    int major;
    major = int'(ins[15:12]);
    if (imm_mask[major]) begin
      op  = {ins[15:12], 4'h0};
      fmt = (major == 12) ? 2'd2 : 2'd1;
      if (zmask[major] || !ins[7]) imm = {8'h00, ins[7:0]};
      else                         imm = {8'hFF, ins[7:0]};
    end else begin
      op  = {ins[15:12], ins[7:4]};
      fmt = 2'd0;
      imm = 16'h0000;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [7:0]  op;
    logic [1:0]  fmt;
    logic [15:0] imm;
    logic [7:0]  zop;
    logic [1:0]  zfmt;
    logic [15:0] zimm;
    if (!reset_n) return;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("retired_count", 32'(retired_count), 32'(m_ret));
    chk("z_out_valid", 32'(z_out_valid), 32'(m_valid));
    if (m_valid) begin
      exp_decode(m_instr, zmask_dflt, op, fmt, imm);
      exp_decode(m_instr, zmask_z, zop, zfmt, zimm);
      chk("out_instr", 32'(out_instr), 32'(m_instr));
      chk("out_op", 32'(out_op), 32'(op));
      chk("out_fmt", 32'(out_fmt), 32'(fmt));
      chk("out_rdest", 32'(out_rdest), 32'(m_instr[11:8]));
      chk("out_rsrc", 32'(out_rsrc), 32'(m_instr[3:0]));
      chk("out_imm", 32'(out_imm), 32'(imm));
      chk("z_out_imm", 32'(z_out_imm), 32'(zimm));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [15:0] ins);
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset retired", 32'(retired_count), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_op", 32'(out_op), 32'd0);
    chk("reset out_imm", 32'(out_imm), 32'd0);
    chk("reset out_instr", 32'(out_instr), 32'd0);

    // Bypass and decode of each format.
    send(16'h0295);
    chk("bypass valid", 32'(out_valid), 32'd1);
    chk("rr op", 32'(out_op), 32'h09);
    chk("rr fmt", 32'(out_fmt), 32'd0);
    chk("rr rdest", 32'(out_rdest), 32'd2);
    chk("rr rsrc", 32'(out_rsrc), 32'd5);
    chk("rr imm", 32'(out_imm), 32'd0);
    chk("bypass occ", 32'(occupancy), 32'd0);
    send(16'h53F0);
    chk("imm op", 32'(out_op), 32'h50);
    chk("imm fmt", 32'(out_fmt), 32'd1);
    chk("imm sext", 32'(out_imm), 32'hFFF0);
    chk("imm zext", 32'(z_out_imm), 32'h00F0);
    send(16'hC410);
    chk("br op", 32'(out_op), 32'hC0);
    chk("br fmt", 32'(out_fmt), 32'd2);
    chk("br imm", 32'(out_imm), 32'h0010);
    send(16'h8142);
    chk("rr8 op", 32'(out_op), 32'h84);
    chk("rr8 fmt", 32'(out_fmt), 32'd0);
    tick();
    chk("drain valid", 32'(out_valid), 32'd0);
    chk("drain retired", 32'(retired_count), 32'd4);

    // Backpressure until full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = 16'h1000 + 16'(i);
      tick();
    end
    chk("full occ", 32'(occupancy), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full held", 32'(out_instr), 32'h1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("release order", 32'(out_instr), 32'h1000 + 32'(j));
    end
    tick();
    chk("release valid", 32'(out_valid), 32'd0);
    chk("release retired", 32'(retired_count), 32'd9);

    // Simultaneous push and pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 16'h2000 + 16'(i);
      tick();
    end
    chk("pp occ", 32'(occupancy), 32'd2);
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      in_instr = 16'h2000 + 16'(i);
      tick();
      chk("pp occ steady", 32'(occupancy), 32'd2);
      chk("pp order", 32'(out_instr), 32'h2000 + 32'(i - 2));
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // Flush with an offered input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 16'h3000 + 16'(i);
      tick();
    end
    chk("pre-flush occ", 32'(occupancy), 32'd3);
    chk("pre-flush valid", 32'(out_valid), 32'd1);
    flush    = 1'b1;
    in_instr = 16'h3ABC;
    tick();
    chk("flush occ", 32'(occupancy), 32'd0);
    chk("flush valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush dropped", 32'(out_valid), 32'd0);

    // Randomised traffic, alternating phases of light and heavy backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = 16'($urandom);
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset while loaded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 16'($urandom) | 16'h00FF;
      tick();
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset out_valid", 32'(out_valid), 32'd0);
    chk("areset out_op", 32'(out_op), 32'd0);
    chk("areset out_fmt", 32'(out_fmt), 32'd0);
    chk("areset out_rdest", 32'(out_rdest), 32'd0);
    chk("areset out_rsrc", 32'(out_rsrc), 32'd0);
    chk("areset out_imm", 32'(out_imm), 32'd0);
    chk("areset out_instr", 32'(out_instr), 32'd0);
    chk("areset occupancy", 32'(occupancy), 32'd0);
    chk("areset retired", 32'(retired_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();
    for (int i = 0; i < 40; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_instr  = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
